// File: rtl/hamming_secded_stream.sv
// Streaming SECDED Hamming decoder. A two-stage valid/ready pipeline corrects
// single-bit errors, flags double-bit errors and counts both kinds of error.
module hamming_secded_stream #(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int R      = $clog2(DATA_W + $clog2(DATA_W) + 32'sd1),
    localparam int CODE_W = DATA_W + R + 32'sd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [R-1:0]      out_syndrome,
    output logic              out_sec,
    output logic              out_ded,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count
);

    function automatic logic is_pow2(input int pos);
        return (pos & (pos - 32'sd1)) == 32'sd0;
    endfunction

    // Hamming position (1-based) that carries payload bit j.
    function automatic int data_pos(input int j);
        int cnt;
        int pos;
        cnt = 32'sd0;
        pos = 32'sd0;
        for (int i = 1; i < CODE_W; i++) begin
            if (!is_pow2(i)) begin
                if (cnt == j) begin
                    pos = i;
                end
                cnt = cnt + 32'sd1;
            end
        end
        return pos;
    endfunction

    function automatic logic [R-1:0] calc_syndrome(input logic [CODE_W-1:0] code);
        logic [R-1:0] s;
        s = '0;
        for (int i = 1; i < CODE_W; i++) begin
            for (int k = 0; k < R; k++) begin
                s[k] = s[k] ^ (code[i - 32'sd1] & i[k]);
            end
        end
        return s;
    endfunction

    function automatic logic calc_parity(input logic [CODE_W-1:0] code);
        return ^code;
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int j = 0; j < DATA_W; j++) begin
            d[j] = code[data_pos(j) - 32'sd1];
        end
        return d;
    endfunction

    logic              r_s1_valid;
    logic [R-1:0]      r_s1_syn;
    logic              r_s1_par;
    logic [DATA_W-1:0] r_s1_data;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [R-1:0]      r_out_syn;
    logic              r_out_sec;
    logic              r_out_ded;
    logic [CNT_W-1:0]  r_sec_cnt;
    logic [CNT_W-1:0]  r_ded_cnt;

    logic              w_e1;
    logic              w_e2;
    logic              w_out_fire;
    logic              w_syn_zero;
    logic              w_syn_in_range;
    logic              w_flip;
    logic              w_sec;
    logic              w_ded;
    logic [DATA_W-1:0] w_corr_data;

    assign w_e2       = !r_s2_valid || out_ready;
    assign w_e1       = !r_s1_valid || w_e2;
    assign in_ready   = rst_n && w_e1;
    assign w_out_fire = r_s2_valid && out_ready;

    assign w_syn_zero     = (r_s1_syn == '0);
    assign w_syn_in_range = (int'(r_s1_syn) < CODE_W);

    // Stage 1: syndrome, overall parity and raw payload of the accepted word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_syn   <= '0;
            r_s1_par   <= 1'b0;
            r_s1_data  <= '0;
        end else if (w_e1) begin
            r_s1_valid <= in_valid;
            r_s1_syn   <= calc_syndrome(in_code);
            r_s1_par   <= calc_parity(in_code);
            r_s1_data  <= extract_data(in_code);
        end
    end

    // Classify the stage-1 word from its parity and syndrome.
    always_comb begin
        w_sec  = 1'b0;
        w_ded  = 1'b0;
        w_flip = 1'b0;
        case ({r_s1_par, w_syn_zero})
            2'b01: begin
                w_sec = 1'b0;
                w_ded = 1'b0;
            end
            2'b11: begin
                w_sec = 1'b1;
            end
            2'b10: begin
                if (w_syn_in_range) begin
                    w_sec  = 1'b1;
                    w_flip = 1'b1;
                end else begin
                    w_ded = 1'b1;
                end
            end
            2'b00: begin
                w_ded = 1'b1;
            end
            default: begin
                w_ded = 1'b1;
            end
        endcase
    end

    // Flip the payload bit named by the syndrome; parity positions leave data untouched.
    always_comb begin
        w_corr_data = r_s1_data;
        for (int j = 0; j < DATA_W; j++) begin
            if (w_flip && (data_pos(j) == int'(r_s1_syn))) begin
                w_corr_data[j] = ~r_s1_data[j];
            end else begin
                w_corr_data[j] = r_s1_data[j];
            end
        end
    end

    // Stage 2: registered result, held while the sink stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_syn  <= '0;
            r_out_sec  <= 1'b0;
            r_out_ded  <= 1'b0;
        end else if (w_e2) begin
            r_s2_valid <= r_s1_valid;
            r_out_data <= w_corr_data;
            r_out_syn  <= r_s1_syn;
            r_out_sec  <= w_sec;
            r_out_ded  <= w_ded;
        end
    end

    // Saturating error counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else if (clr_cnt) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else begin
            if (w_out_fire && r_out_sec && (r_sec_cnt != {CNT_W{1'b1}})) begin
                r_sec_cnt <= r_sec_cnt + CNT_W'(1'b1);
            end
            if (w_out_fire && r_out_ded && (r_ded_cnt != {CNT_W{1'b1}})) begin
                r_ded_cnt <= r_ded_cnt + CNT_W'(1'b1);
            end
        end
    end

    assign out_valid    = r_s2_valid;
    assign out_data     = r_out_data;
    assign out_syndrome = r_out_syn;
    assign out_sec      = r_out_sec;
    assign out_ded      = r_out_ded;
    assign sec_count    = r_sec_cnt;
    assign ded_count    = r_ded_cnt;

endmodule

// File: doc/hamming_secded_stream.md
HAMMING_SECDED_STREAM -- requirements
Module: hamming_secded_stream

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_W, 8, payload width in bits, legal range 4..57
  CNT_W, 16, width of each error counter, legal range 2..32
REQ-002 Derived constants SHALL be fixed as follows.
  - R = smallest integer with 2^R >= DATA_W+R+1
  - CODE_W = DATA_W+R+1
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  reset; synchronous and active-low
  in_valid  in  1  in_code valid
  in_ready  out  1  block accepts in_code this cycle
  in_code  in  CODE_W  received SECDED codeword
  out_valid  out  1  result valid
  out_ready  in  1  sink accepts result
  out_data  out  DATA_W  corrected payload
  out_syndrome  out  R  Hamming syndrome of the word
  out_sec  out  1  single error corrected
  out_ded  out  1  uncorrectable error detected
  clr_cnt  in  1  synchronous clear of both counters
  sec_count  out  CNT_W  saturating count of delivered SEC results
  ded_count  out  CNT_W  saturating count of delivered DED results
REQ-004 Codeword layout SHALL be fixed as follows.
  - code[i-1] = Hamming position i, for i = 1..CODE_W-1.
  - Power-of-two positions hold parity; all other positions hold data, ascending (data[0] at position 3).
  - code[CODE_W-1] holds overall even parity of code[CODE_W-2:0].

Function
REQ-005 Syndrome bit k SHALL be the XOR of all code[i-1] whose position i has bit k set; P SHALL be the XOR of all CODE_W bits.
REQ-006 Classification SHALL be as follows.
  - S=0, P=0: clean; sec=0, ded=0.
  - S=0, P=1: overall-parity bit error; sec=1, payload unchanged.
  - S in 1..CODE_W-1, P=1: flip position S, sec=1.
  - S>CODE_W-1, P=1: ded=1.
  - S!=0, P=0: ded=1.
REQ-007 On ded=1, out_data SHALL carry the raw, uncorrected data bits; out_sec and out_ded SHALL never both be 1.
REQ-008 The datapath SHALL be a 2-stage pipeline.
  - Stage 1 registers syndrome, P and data bits.
  - Stage 2 registers the corrected payload and flags.
  - Latency is 2 cycles from input handshake to out_valid with out_ready held high.
  - Throughput is 1 word per cycle.
REQ-009 Stall rules SHALL be as follows.
  - e2 = !s2_valid || out_ready
  - e1 = !s1_valid || e2
  - in_ready = rst_n && e1
  - A stage holds its contents when not enabled.
REQ-010 A transfer SHALL occur only when valid and ready are both high; out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-011 in_ready SHALL be combinational from out_ready and pipeline state, with no registered bubble; a full pipeline SHALL accept a new word in the same cycle out_ready=1.
REQ-012 Each counter SHALL increment by 1 only on an output handshake carrying its flag.
  - Counters saturate at 2^CNT_W-1.
  - clr_cnt=1 zeroes both counters and wins over a simultaneous increment.

Reset
REQ-013 While rst_n=0 at a clock edge, the following SHALL be 0: s1_valid, s2_valid, out_valid, out_data, out_syndrome, out_sec, out_ded, sec_count, ded_count.
REQ-014 While rst_n=0, in_ready SHALL be 0; words in flight at reset SHALL be discarded and SHALL NOT be counted.
REQ-015 The first input handshake SHALL be possible in the first cycle with rst_n=1.

Verification
REQ-016 DATA_W=4, in_code=8'h55, out_ready=1 -> 2 cycles later out_data=4'hB, out_syndrome=0, out_sec=0, out_ded=0.
REQ-017 DATA_W=4, in_code=8'h45 -> out_data=4'hB, out_syndrome=5, out_sec=1, sec_count+1. in_code=8'hD5 -> out_data=4'hB, out_syndrome=0, out_sec=1.
REQ-018 DATA_W=4, in_code=8'h47 -> out_syndrome=7, out_ded=1, out_data=4'h9 (raw), ded_count+1.
REQ-019 DATA_W=8, in_code=13'h0089 -> out_syndrome=13 (out of range), out_ded=1, out_data=8'h00.
REQ-020 Backpressure and saturation scenario:
  - Stimulus: back-to-back 8'h55/8'h45/8'h47 with out_ready low for 3 cycles mid-stream.
  - Required: no loss or duplication, in_ready=0 while both stages full, outputs stable.
  - With CNT_W=2 and 5 SEC words: sec_count stops at 3.
  - clr_cnt together with an SEC handshake leaves sec_count=0.
REQ-021 Reset mid-stream scenario:
  - Stimulus: rst_n=0 for 1 cycle with both stages full.
  - Required: out_valid=0 and counters 0 next cycle, in_ready=0 during reset.
